// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_pkg / dmem_responder_if
// Pipeline slot types shared by EX/MEM and MEM/WB, plus the handshake bundle
// between the MEM stage and the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;
  localparam int IDX_RS1 = 0;
  localparam int IDX_RS2 = 1;
  localparam int IDX_RD  = 2;

  typedef struct packed {
    logic [63:0]     PC;
    logic [63:0]     PC_Next;
    logic [63:0]     ALU_Result;
    logic [63:0]     Store_Data;
    logic [2:0][4:0] RegIdx;
    logic            Reg_WEn;
    logic            Mem_REn;
    logic            Mem_WEn;
    logic [2:0]      Detail;
  } EXMEM_Pipe_Out_t;

  typedef struct packed {
    logic [63:0] PC;
    logic [63:0] PC_Next;
    logic [63:0] WB_Data;
    logic [4:0]  RD_Addr;
    logic        Reg_WEn;
    logic        enable;
  } MEMWB_Pipe_t;
endpackage

interface dmem_responder_if;
  import dmem_pkg::*;

  logic            in_valid;
  logic            in_ready;
  EXMEM_Pipe_Out_t in_pipe;
  logic            out_valid;
  logic            out_ready;
  MEMWB_Pipe_t     out_pipe;
  logic            misalign;
  logic            stall_req;

  modport slave (
    input  in_valid, in_pipe, out_ready,
    output in_ready, out_valid, out_pipe, misalign, stall_req
  );

  modport master (
    output in_valid, in_pipe, out_ready,
    input  in_ready, out_valid, out_pipe, misalign, stall_req
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder
// MEM-stage responder: accepts one EX/MEM slot per handshake, performs an
// aligned load/store on an internal byte-addressed RAM after a fixed latency
// and returns the formatted MEM/WB slot. Non-memory slots pass in one cycle.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 16,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int WORDS = 2 ** (RAM_SIZE - 3);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  EXMEM_Pipe_Out_t   req_q, req_d;
  MEMWB_Pipe_t       out_pipe_q, out_pipe_d;
  logic              misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  // Address decode of the captured slot
  logic [RAM_SIZE-1:0]   w_addr;
  logic [RAM_SIZE-4:0]   w_word;
  logic [2:0]            w_lane;
  logic [1:0]            w_size;
  assign w_addr = req_q.ALU_Result[RAM_SIZE-1:0];
  assign w_word = w_addr[RAM_SIZE-1:3];
  assign w_lane = w_addr[2:0];
  assign w_size = req_q.Detail[1:0];

  // Error classification: misaligned, illegal width code, or both enables set
  logic w_misal, w_illegal, w_err;
  assign w_misal   = (w_size == 2'b01) ? w_addr[0]
                   : (w_size == 2'b10) ? |w_addr[1:0]
                   : (w_size == 2'b11) ? |w_addr[2:0]
                   : 1'b0;
  assign w_illegal = (req_q.Detail == 3'b111) | (req_q.Mem_WEn & req_q.Detail[2]);
  assign w_err     = w_misal | w_illegal | (req_q.Mem_REn & req_q.Mem_WEn);

  // Load path: read the word, shift the addressed lane down to bit 0
  logic [DATA_WIDTH-1:0] w_rword, w_shift, w_load;
  assign w_rword = mem_q[w_word];
  assign w_shift = w_rword >> {w_lane, 3'b000};

  // Format the loaded value according to width and signedness
  always_comb begin
    w_load = '0;
    case (req_q.Detail)
      3'b000:  w_load = {{56{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_load = {{48{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_load = {{32{w_shift[31]}}, w_shift[31:0]};
      3'b011:  w_load = w_shift;
      3'b100:  w_load = {56'd0, w_shift[7:0]};
      3'b101:  w_load = {48'd0, w_shift[15:0]};
      3'b110:  w_load = {32'd0, w_shift[31:0]};
      default: w_load = '0;
    endcase
  end

  // Store path: merge the low bytes of Store_Data into the selected lanes
  logic [7:0]            w_size_mask, w_bmask;
  logic [DATA_WIDTH-1:0] w_smask, w_sdata, w_wdata;
  assign w_size_mask = (w_size == 2'b00) ? 8'h01
                     : (w_size == 2'b01) ? 8'h03
                     : (w_size == 2'b10) ? 8'h0F
                     : 8'hFF;
  assign w_bmask = w_size_mask << w_lane;
  assign w_sdata = req_q.Store_Data << {w_lane, 3'b000};

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign w_smask[8*gi +: 8] = {8{w_bmask[gi]}};
  end

  assign w_wdata = (w_rword & ~w_smask) | (w_sdata & w_smask);

  logic w_access_done, w_mem_we;
  assign w_access_done = (state_q == S_ACCESS) && (cnt_q == '0);
  // A store caught by reset on its commit edge is dropped
  assign w_mem_we      = w_access_done & req_q.Mem_WEn & ~w_err & rst_n;

  // Responses for the captured memory slot and for an incoming ALU slot
  MEMWB_Pipe_t w_mem_resp, w_alu_resp;
  always_comb begin
    w_mem_resp         = '0;
    w_mem_resp.PC      = req_q.PC;
    w_mem_resp.PC_Next = req_q.PC_Next;
    w_mem_resp.RD_Addr = req_q.RegIdx[IDX_RD];
    w_mem_resp.WB_Data = req_q.Mem_REn ? w_load : req_q.ALU_Result;
    w_mem_resp.Reg_WEn = req_q.Reg_WEn & ~req_q.Mem_WEn & ~w_err;
    w_mem_resp.enable  = 1'b1;

    w_alu_resp         = '0;
    w_alu_resp.PC      = bus.in_pipe.PC;
    w_alu_resp.PC_Next = bus.in_pipe.PC_Next;
    w_alu_resp.RD_Addr = bus.in_pipe.RegIdx[IDX_RD];
    w_alu_resp.WB_Data = bus.in_pipe.ALU_Result;
    w_alu_resp.Reg_WEn = bus.in_pipe.Reg_WEn;
    w_alu_resp.enable  = 1'b1;
  end

  logic w_in_ready, w_accept, w_in_is_mem;
  assign w_in_ready  = (state_q == S_IDLE) | ((state_q == S_RESP) & bus.out_ready);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_in_is_mem = bus.in_pipe.Mem_REn | bus.in_pipe.Mem_WEn;

  // Next-state: latency countdown, response hand-off and slot dispatch
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    out_pipe_d = out_pipe_q;
    misalign_d = misalign_q;

    case (state_q)
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_pipe_d = w_mem_resp;
          misalign_d = w_err;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      S_IDLE: ;
      default: state_d = S_IDLE;
    endcase

    if (w_accept) begin
      req_d = bus.in_pipe;
      if (w_in_is_mem) begin
        state_d = S_ACCESS;
        cnt_d   = CNT_W'(LATENCY - 1);
      end else begin
        out_pipe_d = w_alu_resp;
        misalign_d = 1'b0;
        state_d    = S_RESP;
      end
    end
  end

  // Control and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      out_pipe_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      out_pipe_q <= out_pipe_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) mem_q[w_word] <= w_wdata;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == S_RESP);
  assign bus.out_pipe  = out_pipe_q;
  assign bus.misalign  = misalign_q;
  assign bus.stall_req = bus.in_valid & ~w_in_ready;

  // Source-register indices travel with the slot but are not needed here
  logic w_unused_regidx;
  assign w_unused_regidx = ^{req_q.RegIdx[IDX_RS1], req_q.RegIdx[IDX_RS2]};

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder
// Directed bench: byte-level memory model with an expected-response queue,
// one per-cycle monitor, plus literal expectations for the documented cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if dif();

  dmem_responder #(.DATA_WIDTH(64), .RAM_SIZE(16), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    MEMWB_Pipe_t r;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mdl [65536];
  MEMWB_Pipe_t last_resp;
  logic        last_mis;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic EXMEM_Pipe_Out_t mk(input logic [63:0] alu, input logic [63:0] sd,
                                         input logic [4:0] rd, input logic ren,
                                         input logic wen, input logic [2:0] det);
    EXMEM_Pipe_Out_t s;
    s = '0;
    s.PC = 64'h8000_0000 + {alu[15:0], 4'h0};
    s.PC_Next = s.PC + 64'd4;
    s.ALU_Result = alu;
    s.Store_Data = sd;
    s.RegIdx[IDX_RD] = rd;
    s.RegIdx[IDX_RS1] = 5'd1;
    s.RegIdx[IDX_RS2] = 5'd2;
    s.Reg_WEn = 1'b1;
    s.Mem_REn = ren;
    s.Mem_WEn = wen;
    s.Detail = det;
    return s;
  endfunction

  // Reference behaviour: byte-granular memory, width from Detail
  task automatic predict(input EXMEM_Pipe_Out_t s, input int acc);
    exp_t e;
    logic [15:0] a, ai;
    logic [63:0] v;
    logic is_mem, err;
    int nb;
    a = s.ALU_Result[15:0];
    nb = 1 << s.Detail[1:0];
    is_mem = s.Mem_REn | s.Mem_WEn;
    err = 1'b0;
    if (is_mem) begin
      if (s.Mem_REn && s.Mem_WEn) err = 1'b1;
      if (s.Detail == 3'b111) err = 1'b1;
      if (s.Mem_WEn && s.Detail[2]) err = 1'b1;
      if ((int'(a) % nb) != 0) err = 1'b1;
    end
    e.r = '0;
    e.r.PC = s.PC;
    e.r.PC_Next = s.PC_Next;
    e.r.RD_Addr = s.RegIdx[IDX_RD];
    e.r.WB_Data = s.ALU_Result;
    e.r.Reg_WEn = s.Reg_WEn & ~s.Mem_WEn & ~err;
    e.r.enable = 1'b1;
    e.mis = err;
    e.cyc = acc + (is_mem ? LAT : 0);
    if (s.Mem_REn && !err) begin
      v = '0;
      for (int i = 0; i < nb; i++) begin
        ai = a + 16'(i);
        v = v | (64'(mdl[ai]) << (8 * i));
      end
      if (!s.Detail[2] && nb < 8 && v[8*nb-1]) v = v | (~64'h0 << (8 * nb));
      e.r.WB_Data = v;
    end
    if (s.Mem_WEn && !err) begin
      for (int i = 0; i < nb; i++) begin
        ai = a + 16'(i);
        mdl[ai] = s.Store_Data[8*i +: 8];
      end
    end
    exp_q.push_back(e);
  endtask

  // Present a slot from a falling edge until it is accepted (bounded)
  task automatic send(input EXMEM_Pipe_Out_t s);
    bit done;
    done = 1'b0;
    dif.in_pipe = s;
    dif.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (dif.in_ready) begin
        predict(s, cyc + 1);
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no in_ready expected in_ready within 50 cycles");
    end
    dif.in_valid = 1'b0;
  endtask

  // Wait until every expected response has been consumed (bounded)
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", exp_q.size());
    end
  endtask

  // Per-cycle monitor: stall rule, latency, hold stability, response content
  bit          prev_valid = 1'b0;
  bit          prev_fire  = 1'b0;
  MEMWB_Pipe_t held_pipe;
  logic        held_mis;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      chk("stall_req", 64'(dif.stall_req), 64'(dif.in_valid & ~dif.in_ready));
      if (dif.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got out_valid=1 rd=%0d expected out_valid=0",
                   dif.out_pipe.RD_Addr);
        end else begin
          if (!prev_valid || prev_fire) begin
            chk("resp_latency", 64'(cyc), 64'(exp_q[0].cyc));
          end else begin
            chk("hold_wb", dif.out_pipe.WB_Data, held_pipe.WB_Data);
            chk("hold_rd", 64'(dif.out_pipe.RD_Addr), 64'(held_pipe.RD_Addr));
            chk("hold_mis", 64'(dif.misalign), 64'(held_mis));
          end
          held_pipe = dif.out_pipe;
          held_mis  = dif.misalign;
          if (dif.out_ready) begin
            chk("resp_pc", dif.out_pipe.PC, exp_q[0].r.PC);
            chk("resp_pcn", dif.out_pipe.PC_Next, exp_q[0].r.PC_Next);
            chk("resp_rd", 64'(dif.out_pipe.RD_Addr), 64'(exp_q[0].r.RD_Addr));
            chk("resp_wen", 64'(dif.out_pipe.Reg_WEn), 64'(exp_q[0].r.Reg_WEn));
            chk("resp_en", 64'(dif.out_pipe.enable), 64'(exp_q[0].r.enable));
            chk("resp_mis", 64'(dif.misalign), 64'(exp_q[0].mis));
            if (!exp_q[0].mis) chk("resp_wb", dif.out_pipe.WB_Data, exp_q[0].r.WB_Data);
            last_resp = dif.out_pipe;
            last_mis  = dif.misalign;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = dif.out_valid;
      prev_fire  = dif.out_valid & dif.out_ready;
    end
  end

  task automatic xact(input EXMEM_Pipe_Out_t s);
    send(s);
    drain();
  endtask

  initial begin
    dif.in_valid  = 1'b0;
    dif.in_pipe   = '0;
    dif.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_misalign", 64'(dif.misalign), 64'd0);
    chk("rst_out_wb", dif.out_pipe.WB_Data, 64'd0);
    chk("rst_in_ready", 64'(dif.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word store then load
    xact(mk(64'h100, 64'h1122334455667788, 5'd3, 1'b0, 1'b1, 3'b011));
    chk("sd_reg_wen", 64'(last_resp.Reg_WEn), 64'd0);
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b011));
    chk("ld_0x100", last_resp.WB_Data, 64'h1122334455667788);

    // Narrow loads from the same word
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b000));
    chk("lb_0x100", last_resp.WB_Data, 64'hFFFFFFFFFFFFFF88);
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b100));
    chk("lbu_0x100", last_resp.WB_Data, 64'h88);
    xact(mk(64'h106, 64'h0, 5'd4, 1'b1, 1'b0, 3'b001));
    chk("lh_0x106", last_resp.WB_Data, 64'h1122);
    xact(mk(64'h104, 64'h0, 5'd4, 1'b1, 1'b0, 3'b010));
    chk("lw_0x104", last_resp.WB_Data, 64'h11223344);
    xact(mk(64'h104, 64'h0, 5'd4, 1'b1, 1'b0, 3'b110));
    xact(mk(64'h101, 64'hAB, 5'd3, 1'b0, 1'b1, 3'b000));
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b011));
    chk("ld_after_sb", last_resp.WB_Data, 64'h112233445566AB88);

    // Error cases
    xact(mk(64'h102, 64'h0, 5'd7, 1'b1, 1'b0, 3'b010));
    chk("lw_mis_flag", 64'(last_mis), 64'd1);
    chk("lw_mis_wen", 64'(last_resp.Reg_WEn), 64'd0);
    chk("lw_mis_rd", 64'(last_resp.RD_Addr), 64'd7);
    xact(mk(64'h103, 64'hDEADBEEF, 5'd3, 1'b0, 1'b1, 3'b010));
    chk("sw_mis_flag", 64'(last_mis), 64'd1);
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b111));
    xact(mk(64'h100, 64'h5555, 5'd3, 1'b0, 1'b1, 3'b101));
    xact(mk(64'h100, 64'h6666, 5'd3, 1'b1, 1'b1, 3'b011));
    xact(mk(64'h100, 64'h0, 5'd4, 1'b1, 1'b0, 3'b011));
    chk("ld_unchanged", last_resp.WB_Data, 64'h112233445566AB88);

    // Back-to-back ALU slots, then back-pressure in RESP
    dif.out_ready = 1'b1;
    send(mk(64'h42, 64'h0, 5'd5, 1'b0, 1'b0, 3'b000));
    chk("b2b_in_ready", 64'(dif.in_ready), 64'd1);
    send(mk(64'h43, 64'h0, 5'd6, 1'b0, 1'b0, 3'b000));
    dif.out_ready = 1'b0;
    dif.in_pipe = mk(64'h44, 64'h0, 5'd8, 1'b0, 1'b0, 3'b000);
    dif.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 64'(dif.in_ready), 64'd0);
      chk("bp_stall", 64'(dif.stall_req), 64'd1);
      chk("bp_rd", 64'(dif.out_pipe.RD_Addr), 64'd6);
      chk("bp_wb", dif.out_pipe.WB_Data, 64'h43);
      @(negedge clk);
    end
    dif.out_ready = 1'b1;
    send(mk(64'h44, 64'h0, 5'd8, 1'b0, 1'b0, 3'b000));
    drain();
    chk("alu_rd8", 64'(last_resp.RD_Addr), 64'd8);

    // Address wrap
    xact(mk(64'h10000, 64'hCAFE, 5'd3, 1'b0, 1'b1, 3'b011));
    xact(mk(64'h0, 64'h0, 5'd4, 1'b1, 1'b0, 3'b011));
    chk("ld_wrap", last_resp.WB_Data, 64'hCAFE);

    // Reset on the commit edge of a store drops it
    xact(mk(64'h200, 64'h0123456789ABCDEF, 5'd3, 1'b0, 1'b1, 3'b011));
    dif.in_pipe = mk(64'h200, 64'hFFFFFFFFFFFFFFFF, 5'd3, 1'b0, 1'b1, 3'b011);
    dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_acc_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_acc_mis", 64'(dif.misalign), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xact(mk(64'h200, 64'h0, 5'd4, 1'b1, 1'b0, 3'b011));
    chk("ld_after_rst", last_resp.WB_Data, 64'h0123456789ABCDEF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
